// File: rtl/ariane_regfile_lvt.sv
// ariane_regfile_lvt
//   Multi-ported register file for FPGA targets. Every write port owns one RAM bank,
//   and a live-value table (LVT) records which bank holds the newest copy of each
//   register. After reset, or on clear_i, a sequencer sweeps the whole file to zero.
//   Until that sweep finishes, ready_o stays low, writes are ignored and reads return 0.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous reset, active low
//   clear_i        request to re-zero the entire file
//   ready_o        1 = init/clear sweep finished, reads and writes valid
//   raddr_i        NR_READ_PORTS packed read addresses
//   rdata_o        NR_READ_PORTS packed read data (combinational)
//   waddr_i        NR_WRITE_PORTS packed write addresses
//   wdata_i        NR_WRITE_PORTS packed write data
//   we_i           per-port write enables
//   wr_conflict_o  registered: two or more enabled ports hit the same address last cycle
//
// Configuration macro
//   REGFILE_BYPASS_EN  when defined, a read whose address matches an accepted write in
//                      the same cycle returns that write data (highest port index wins).

module ariane_regfile_lvt #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned NR_REGS        = 32,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter bit          ZERO_REG_ZERO  = 1'b0,
    localparam int unsigned AW = $clog2(NR_REGS),
    localparam int unsigned LW = (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    output logic                                 ready_o,
    input  logic [NR_READ_PORTS*AW-1:0]          raddr_i,
    output logic [NR_READ_PORTS*DATA_WIDTH-1:0]  rdata_o,
    input  logic [NR_WRITE_PORTS*AW-1:0]         waddr_i,
    input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]            we_i,
    output logic                                 wr_conflict_o
);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                state_q;
    logic [AW-1:0]         cnt_q;
    logic                  conflict_d, conflict_q;
    logic                  ready;

    logic [LW-1:0]         lvt_q [NR_REGS];
    // RAM banks carry no reset; the init sweep zeroes them instead.
    logic [DATA_WIDTH-1:0] mem_q [NR_WRITE_PORTS][NR_REGS];

    logic [AW-1:0]         waddr [NR_WRITE_PORTS];
    logic [DATA_WIDTH-1:0] wdata [NR_WRITE_PORTS];
    logic [NR_WRITE_PORTS-1:0] wr_ok;

    assign ready         = (state_q == StReady);
    assign ready_o       = ready;
    assign wr_conflict_o = conflict_q;

    // Unpack write ports and qualify enables: no writes while sweeping, and
    // address 0 is dropped when it is hardwired to zero.
    always_comb begin
        for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
            waddr[j] = waddr_i[j*AW +: AW];
            wdata[j] = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
            wr_ok[j] = ready && we_i[j] && !(ZERO_REG_ZERO && (waddr[j] == '0));
        end
    end

    // Pairwise collision detect; qualified enables already exclude non-ready and addr 0.
    always_comb begin
        conflict_d = 1'b0;
        for (int unsigned a = 0; a < NR_WRITE_PORTS; a++) begin
            for (int unsigned b = a + 1; b < NR_WRITE_PORTS; b++) begin
                if (wr_ok[a] && wr_ok[b] && (waddr[a] == waddr[b])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Init/clear sequencer. A clear during the sweep restarts it from entry 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
            unique case (state_q)
                StInit: begin
                    if (clear_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == AW'(NR_REGS - 1)) begin
                        state_q <= StReady;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                StReady: begin
                    if (clear_i) begin
                        state_q <= StInit;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= StInit;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Live-value table. Ports are visited in ascending order, so the last
    // non-blocking assignment (highest enabled port index) wins on collisions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_REGS; i++) begin
                lvt_q[i] <= '0;
            end
        end else if (state_q == StInit) begin
            lvt_q[cnt_q] <= '0;
        end else begin
            for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
                if (wr_ok[j]) begin
                    lvt_q[waddr[j]] <= LW'(j);
                end
            end
        end
    end

    // RAM banks: the sweep only needs to clear bank 0 because the LVT points there.
    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            mem_q[0][cnt_q] <= '0;
        end else begin
            for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
                if (wr_ok[j]) begin
                    mem_q[j][waddr[j]] <= wdata[j];
                end
            end
        end
    end

    // Combinational read through the LVT.
    always_comb begin
        logic [AW-1:0]         ra;
        logic [DATA_WIDTH-1:0] rd;
        ra      = '0;
        rd      = '0;
        rdata_o = '0;
        for (int unsigned k = 0; k < NR_READ_PORTS; k++) begin
            ra = raddr_i[k*AW +: AW];
            rd = mem_q[lvt_q[ra]][ra];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
                if (wr_ok[j] && (waddr[j] == ra)) begin
                    rd = wdata[j];
                end
            end
`else
`endif
            if (!ready || (ZERO_REG_ZERO && (ra == '0))) begin
                rd = '0;
            end
            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd;
        end
    end

endmodule

// File: tb/tb_ariane_regfile_lvt.sv
// Self-checking bench for ariane_regfile_lvt. Two instances share all inputs: one with
// default parameters and one with ZERO_REG_ZERO=1. Every cycle, the expected outputs of
// both are pushed to a scoreboard queue. They are popped and compared at the falling edge.
module tb_ariane_regfile_lvt;

    localparam int DW = 64;
    localparam int NR = 32;
    localparam int AW = 5;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           clear = 1'b0;
    logic [2*AW-1:0] raddr = '0;
    logic [2*AW-1:0] waddr = '0;
    logic [2*DW-1:0] wdata = '0;
    logic [1:0]      we    = '0;
    logic [2*DW-1:0] rdata_a, rdata_b;
    logic            ready_a, ready_b, conf_a, conf_b;

    always #5 clk = ~clk;

    ariane_regfile_lvt u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .ready_o       (ready_a),
        .raddr_i       (raddr),
        .rdata_o       (rdata_a),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .we_i          (we),
        .wr_conflict_o (conf_a)
    );

    ariane_regfile_lvt #(
        .ZERO_REG_ZERO (1'b1)
    ) u_dut_z (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .ready_o       (ready_b),
        .raddr_i       (raddr),
        .rdata_o       (rdata_b),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .we_i          (we),
        .wr_conflict_o (conf_b)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
        int          src;
    } exp_t;

    exp_t  sb_q[$];
    int    total = 0;
    int    bad   = 0;
    string phase = "reset";

    // Reference model: one value per register (the newest write), independent of banking.
    logic [63:0] m_a [NR];
    logic [63:0] m_b [NR];
    bit          m_ready  = 1'b0;
    int          m_cnt    = 0;
    bit          m_conf_a = 1'b0;
    bit          m_conf_b = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int src);
        case (src)
            0: return {63'b0, ready_a};
            1: return {63'b0, ready_b};
            2: return {63'b0, conf_a};
            3: return {63'b0, conf_b};
            4: return rdata_a[63:0];
            5: return rdata_a[127:64];
            6: return rdata_b[63:0];
            default: return rdata_b[127:64];
        endcase
    endfunction

    function automatic logic [63:0] exp_read(input bit zr, input int a);
        logic [63:0] v;
        if (!m_ready) return 64'h0;
        v = zr ? m_b[a] : m_a[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < 2; j++) begin
            if (we[j] && (int'(waddr[j*AW +: AW]) == a) && !(zr && a == 0)) begin
                v = wdata[j*DW +: DW];
            end
        end
`endif
        if (zr && a == 0) v = 64'h0;
        return v;
    endfunction

    task automatic push_one(input string name, input int src, input logic [63:0] exp);
        exp_t e;
        e.tag = {phase, " ", name};
        e.exp = exp;
        e.src = src;
        sb_q.push_back(e);
    endtask

    task automatic push_expect();
        int r0, r1;
        r0 = int'(raddr[AW-1:0]);
        r1 = int'(raddr[2*AW-1:AW]);
        push_one("ready", 0, {63'b0, m_ready});
        push_one("ready_z", 1, {63'b0, m_ready});
        push_one("conflict", 2, {63'b0, m_conf_a});
        push_one("conflict_z", 3, {63'b0, m_conf_b});
        push_one($sformatf("rd0@%0d", r0), 4, exp_read(1'b0, r0));
        push_one($sformatf("rd1@%0d", r1), 5, exp_read(1'b0, r1));
        push_one($sformatf("rd0_z@%0d", r0), 6, exp_read(1'b1, r0));
        push_one($sformatf("rd1_z@%0d", r1), 7, exp_read(1'b1, r1));
    endtask

    task automatic model_edge();
        int a0, a1;
        a0 = int'(waddr[AW-1:0]);
        a1 = int'(waddr[2*AW-1:AW]);
        if (!m_ready) begin
            m_a[m_cnt] = '0;
            m_b[m_cnt] = '0;
            m_conf_a   = 1'b0;
            m_conf_b   = 1'b0;
            if (clear) m_cnt = 0;
            else if (m_cnt == NR - 1) begin
                m_ready = 1'b1;
                m_cnt   = 0;
            end else m_cnt++;
        end else begin
            m_conf_a = (we == 2'b11) && (a0 == a1);
            m_conf_b = (we == 2'b11) && (a0 == a1) && (a0 != 0);
            for (int j = 0; j < 2; j++) begin
                if (we[j]) begin
                    m_a[int'(waddr[j*AW +: AW])] = wdata[j*DW +: DW];
                    if (waddr[j*AW +: AW] != '0) m_b[int'(waddr[j*AW +: AW])] = wdata[j*DW +: DW];
                end
            end
            if (clear) begin
                m_ready = 1'b0;
                m_cnt   = 0;
            end
        end
    endtask

    // One clock cycle: expectations queued, outputs checked mid-cycle, model stepped.
    task automatic run_cycle();
        exp_t e;
        push_expect();
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.src), e.exp);
        end
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic drive(input logic [1:0] w, input int a0, input logic [63:0] d0,
                         input int a1, input logic [63:0] d1,
                         input int r0, input int r1, input bit clr);
        we    = w;
        waddr = {AW'(a1), AW'(a0)};
        wdata = {d1, d0};
        raddr = {AW'(r1), AW'(r0)};
        clear = clr;
    endtask

    task automatic drive_rand(input int amax, input bit clr);
        drive(2'($urandom_range(0, 3)), $urandom_range(0, amax), {$urandom, $urandom},
              $urandom_range(0, amax), {$urandom, $urandom},
              $urandom_range(0, amax), $urandom_range(0, amax), clr);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        #2 rst_n = 1'b0;
        for (int i = 0; i < 2; i++) run_cycle();
        rst_n = 1'b1;

        // T1: sweep with random writes that must be ignored.
        phase = "init";
        for (int i = 0; i < NR; i++) drive_rand(31, 1'b0);
        for (int i = 0; i < NR; i++) begin
            drive_rand(31, 1'b0);
            run_cycle();
            if (i == NR - 1) begin
                drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
            end
        end
        phase = "zeroed";
        for (int i = 0; i < NR / 2; i++) begin
            drive(2'b00, 0, 0, 0, 0, 2 * i, 2 * i + 1, 1'b0);
            run_cycle();
        end

        // T2 / T6: back-to-back writes from different ports, same-cycle read.
        phase = "t2";
        drive(2'b01, 5, 64'hAA, 0, 0, 5, 3, 1'b0); run_cycle();
        drive(2'b10, 0, 0, 5, 64'hBB, 5, 3, 1'b0); run_cycle();
        drive(2'b00, 0, 0, 0, 0, 5, 3, 1'b0);      run_cycle();
        phase = "t6";
        drive(2'b01, 3, 64'h55, 0, 0, 3, 3, 1'b0); run_cycle();
        drive(2'b00, 0, 0, 0, 0, 3, 5, 1'b0);      run_cycle();

        // T3: same-address collision, highest port wins, one-cycle conflict pulse.
        phase = "t3";
        drive(2'b11, 7, 64'h11, 7, 64'h22, 7, 7, 1'b0); run_cycle();
        drive(2'b00, 0, 0, 0, 0, 7, 5, 1'b0);           run_cycle();
        drive(2'b00, 0, 0, 0, 0, 7, 3, 1'b0);           run_cycle();

        // T5: address 0 writes, single and dual.
        phase = "t5";
        drive(2'b01, 0, 64'hFF, 0, 0, 0, 0, 1'b0);      run_cycle();
        drive(2'b11, 0, 64'hFF, 0, 64'hEE, 0, 7, 1'b0); run_cycle();
        drive(2'b00, 0, 0, 0, 0, 0, 7, 1'b0);           run_cycle();
        drive(2'b00, 0, 0, 0, 0, 0, 5, 1'b0);           run_cycle();

        // Random traffic on a narrow address range to provoke collisions.
        phase = "rand";
        for (int i = 0; i < 80; i++) begin
            drive_rand(7, 1'b0);
            run_cycle();
        end

        // Fill every register, then clear; a second clear restarts the sweep.
        phase = "fill";
        for (int i = 0; i < NR / 2; i++) begin
            drive(2'b11, 2 * i, {$urandom, $urandom}, 2 * i + 1, {$urandom, $urandom},
                  2 * i, 31 - 2 * i, 1'b0);
            run_cycle();
        end
        phase = "t4";
        drive(2'b00, 0, 0, 0, 0, 9, 30, 1'b1); run_cycle();
        for (int i = 0; i < 100 && !m_ready; i++) begin
            drive_rand(31, (i == 10));
            run_cycle();
        end
        phase = "cleared";
        for (int i = 0; i < NR / 2; i++) begin
            drive(2'b00, 0, 0, 0, 0, 2 * i, 2 * i + 1, 1'b0);
            run_cycle();
        end

        phase = "tail";
        for (int i = 0; i < 30; i++) begin
            drive_rand(31, 1'b0);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
